mips_irq_ctrl: RTL and testbench

Interrupt controller for the mips789 core. It collects up to N_SRC external interrupt lines, latches them as pending, and applies a software mask. It selects the highest-priority request and presents it to the core's irq_i/irq_addr inputs, then holds the core's single interrupt path busy until software writes end-of-interrupt. Software reaches its registers through the core's coprocessor/data bus.

---
 rtl/mips789_defs.sv | 23 ++
 rtl/mips_irq_ctrl_if.sv | 23 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/mips_irq_ctrl.sv | 121 ++++++++++++
 tb/tb_mips_irq_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips789_defs.sv
// rtl/mips789_defs.sv - shared register offsets, FSM encoding and vector helper for the irq controller
package mips789_defs;

  // Word offsets within the register block, selected by reg_addr_i[3:2]
  localparam logic [1:0] IRQ_PEND = 2'd0;
  localparam logic [1:0] IRQ_MASK = 2'd1;
  localparam logic [1:0] IRQ_STAT = 2'd2;
  localparam logic [1:0] IRQ_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } irq_state_e;

  // Vector address handed to the core for a given source id
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [3:0]  id,
                                           input int unsigned shift);
    return base + ({28'd0, id} << shift);
  endfunction

endpackage

// File: rtl/mips_irq_ctrl_if.sv
// rtl/mips_irq_ctrl_if.sv - core-side interrupt and register bus bundle
interface mips_irq_ctrl_if;
  logic        irq_o;
  logic [31:0] irq_addr_o;
  logic        iack_i;
  logic [31:0] reg_addr_i;
  logic [31:0] reg_din_i;
  logic        reg_we_i;
  logic        reg_re_i;
  logic [31:0] reg_dout_o;

  // Core side: issues bus accesses and acknowledges interrupts
  modport master (
    output iack_i, reg_addr_i, reg_din_i, reg_we_i, reg_re_i,
    input  irq_o, irq_addr_o, reg_dout_o
  );

  // Controller side
  modport slave (
    input  iack_i, reg_addr_i, reg_din_i, reg_we_i, reg_re_i,
    output irq_o, irq_addr_o, reg_dout_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest index wins
module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [3:0]       id_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set bit is the last to overwrite
  always_comb begin
    id_o    = 4'd0;
    valid_o = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_irq_ctrl.sv
// rtl/mips_irq_ctrl.sv - pending/mask interrupt controller with single-level service for mips789
module mips_irq_ctrl
  import mips789_defs::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
  parameter int          VEC_SHIFT = 4,
  parameter logic [31:0] REG_BASE  = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src_i,
  mips_irq_ctrl_if.slave   bus
);

  irq_state_e       state_q;
  logic [N_SRC-1:0] src_q, pend_q, pend_d, mask_q;
  logic [N_SRC-1:0] rise, w1c, req, clr;
  logic [3:0]       id_q, enc_id;
  logic             enc_valid, take, eoi, hit, wr;
  logic [1:0]       off;
  logic             irq_q;
  logic [31:0]      irq_addr_q, dout_q, rd_data;
  logic             unused_ok;

  assign hit  = (bus.reg_addr_i[31:4] == REG_BASE[31:4]);
  assign off  = bus.reg_addr_i[3:2];
  assign wr   = bus.reg_we_i & hit;
  assign eoi  = wr && (off == IRQ_EOI);
  assign rise = irq_src_i & ~src_q;
  assign req  = pend_q & mask_q;
  assign w1c  = (wr && (off == IRQ_PEND)) ? bus.reg_din_i[N_SRC-1:0] : '0;
  assign take = (state_q == ST_IDLE) && enc_valid;

  assign unused_ok = &{1'b0, bus.reg_addr_i[1:0], bus.reg_din_i[31:N_SRC]};

  irq_prio_enc #(.N_SRC(N_SRC)) u_enc (
    .req_i   (req),
    .id_o    (enc_id),
    .valid_o (enc_valid)
  );

  // Pending update: the committed id is consumed, W1C clears, a fresh edge always wins
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (take && (enc_id == 4'(i))) clr[i] = 1'b1;
    end
    pend_d = (pend_q & ~w1c & ~clr) | rise;
  end

  // Read mux; misses and unused bits return zero
  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (off)
        IRQ_PEND: rd_data[N_SRC-1:0] = pend_q;
        IRQ_MASK: rd_data[N_SRC-1:0] = mask_q;
        IRQ_STAT: rd_data = {(state_q != ST_IDLE), 27'd0, id_q};
        default:  rd_data = '0;
      endcase
    end
  end

  // Source sampling, pending, mask and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      dout_q <= '0;
    end else begin
      src_q  <= irq_src_i;
      pend_q <= pend_d;
      if (wr && (off == IRQ_MASK)) mask_q <= bus.reg_din_i[N_SRC-1:0];
      if (bus.reg_re_i) dout_q <= rd_data;
    end
  end

  // Service FSM: commit a request, wait for iack, then hold until EOI
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= 4'd0;
      irq_q      <= 1'b0;
      irq_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enc_valid) begin
            state_q    <= ST_REQ;
            id_q       <= enc_id;
            irq_q      <= 1'b1;
            irq_addr_q <= vec_addr(VEC_BASE, enc_id, VEC_SHIFT);
          end
        end
        ST_REQ: begin
          if (bus.iack_i) begin
            state_q <= ST_SERV;
            irq_q   <= 1'b0;
          end
        end
        ST_SERV: begin
          if (eoi) begin
            state_q <= ST_IDLE;
            id_q    <= 4'd0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_o      = irq_q;
  assign bus.irq_addr_o = irq_addr_q;
  assign bus.reg_dout_o = dout_q;

endmodule

// File: tb/tb_mips_irq_ctrl.sv
// tb/tb_mips_irq_ctrl.sv - self-checking bench for mips_irq_ctrl
module tb_mips_irq_ctrl;

  localparam logic [31:0] RB     = 32'hFFFF_FF00;
  localparam logic [31:0] A_PEND = RB + 32'h0;
  localparam logic [31:0] A_MASK = RB + 32'h4;
  localparam logic [31:0] A_STAT = RB + 32'h8;
  localparam logic [31:0] A_EOI  = RB + 32'hC;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src;
  int         errors = 0;
  int         checks = 0;

  mips_irq_ctrl_if bus_if ();

  mips_irq_ctrl #(
    .N_SRC     (8),
    .VEC_BASE  (32'h0000_0080),
    .VEC_SHIFT (4),
    .REG_BASE  (RB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src_i (irq_src),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.reg_addr_i = a;
    bus_if.reg_din_i  = d;
    bus_if.reg_we_i   = 1'b1;
    tick();
    bus_if.reg_we_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.reg_addr_i = a;
    bus_if.reg_re_i   = 1'b1;
    tick();
    bus_if.reg_re_i   = 1'b0;
    d = bus_if.reg_dout_o;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    irq_src = v;
    tick();
    irq_src = 8'h00;
  endtask

  task automatic pulse_iack;
    bus_if.iack_i = 1'b1;
    tick();
    bus_if.iack_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    if (bus_if.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus_if.irq_o); end
    checks++;
    if (bus_if.irq_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_if.irq_addr_o); end
    checks++;
    if (bus_if.reg_dout_o !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", bus_if.reg_dout_o); end
    checks++;
    rst = 1'b0;
    tick();
    bus_read(A_PEND, d);
    if (d !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h want 0", d); end
    checks++;
    bus_read(A_MASK, d);
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", d); end
    checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h want 0", d); end
    checks++;
  endtask

  task automatic test_basic;
    logic [31:0] d;
    bus_write(A_MASK, 32'h01);
    pulse_src(8'h01);
    tick();
    if (bus_if.irq_o !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b want 1", bus_if.irq_o); end
    checks++;
    if (bus_if.irq_addr_o !== 32'h80) begin errors++; $display("FAIL basic_addr: got %h want 00000080", bus_if.irq_addr_o); end
    checks++;
    pulse_iack();
    if (bus_if.irq_o !== 1'b0) begin errors++; $display("FAIL basic_iack: got %b want 0", bus_if.irq_o); end
    checks++;
    bus_read(A_STAT, d);
    if (d !== 32'h8000_0000) begin errors++; $display("FAIL basic_stat_busy: got %h want 80000000", d); end
    checks++;
    bus_write(A_EOI, 32'h0);
    bus_read(A_STAT, d);
    if (d !== 32'h0) begin errors++; $display("FAIL basic_stat_idle: got %h want 0", d); end
    checks++;
  endtask

  task automatic test_priority;
    bus_write(A_MASK, 32'hFF);
    pulse_src(8'h24);
    tick();
    if (bus_if.irq_addr_o !== 32'hA0 || bus_if.irq_o !== 1'b1) begin
      errors++; $display("FAIL prio_first: got irq=%b addr=%h want irq=1 addr=000000a0", bus_if.irq_o, bus_if.irq_addr_o);
    end
    checks++;
    pulse_iack();
    bus_write(A_EOI, 32'h0);
    tick();
    if (bus_if.irq_addr_o !== 32'hD0 || bus_if.irq_o !== 1'b1) begin
      errors++; $display("FAIL prio_second: got irq=%b addr=%h want irq=1 addr=000000d0", bus_if.irq_o, bus_if.irq_addr_o);
    end
    checks++;
    pulse_iack();
    bus_write(A_EOI, 32'h0);
  endtask

  task automatic test_masked;
    logic [31:0] d;
    bus_write(A_MASK, 32'h00);
    pulse_src(8'h08);
    tick();
    if (bus_if.irq_o !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b want 0", bus_if.irq_o); end
    checks++;
    bus_read(A_PEND, d);
    if (d !== 32'h08) begin errors++; $display("FAIL masked_pend: got %h want 00000008", d); end
    checks++;
    bus_write(A_MASK, 32'h08);
    if (bus_if.irq_o !== 1'b0) begin errors++; $display("FAIL mask_latency: got %b want 0", bus_if.irq_o); end
    checks++;
    tick();
    if (bus_if.irq_o !== 1'b1 || bus_if.irq_addr_o !== 32'hB0) begin
      errors++; $display("FAIL unmask_irq: got irq=%b addr=%h want irq=1 addr=000000b0", bus_if.irq_o, bus_if.irq_addr_o);
    end
    checks++;
    bus_read(A_PEND, d);
    if (d !== 32'h0) begin errors++; $display("FAIL unmask_pend_cleared: got %h want 0", d); end
    checks++;
    pulse_iack();
    bus_write(A_EOI, 32'h0);
  endtask

  task automatic test_serv_reentry;
    logic [31:0] d;
    bus_write(A_MASK, 32'h02);
    pulse_src(8'h02);
    tick();
    if (bus_if.irq_addr_o !== 32'h90) begin errors++; $display("FAIL reentry_first: got %h want 00000090", bus_if.irq_addr_o); end
    checks++;
    pulse_iack();
    pulse_src(8'h02);
    tick();
    if (bus_if.irq_o !== 1'b0) begin errors++; $display("FAIL reentry_no_nest: got %b want 0", bus_if.irq_o); end
    checks++;
    bus_read(A_PEND, d);
    if (d !== 32'h02) begin errors++; $display("FAIL reentry_pend: got %h want 00000002", d); end
    checks++;
    bus_write(A_EOI, 32'h0);
    tick();
    if (bus_if.irq_o !== 1'b1 || bus_if.irq_addr_o !== 32'h90) begin
      errors++; $display("FAIL reentry_again: got irq=%b addr=%h want irq=1 addr=00000090", bus_if.irq_o, bus_if.irq_addr_o);
    end
    checks++;
    pulse_iack();
    bus_write(A_EOI, 32'h0);
  endtask

  task automatic test_w1c_race;
    logic [31:0] d;
    bus_write(A_MASK, 32'h00);
    irq_src = 8'h10;
    bus_write(A_PEND, 32'h10);
    irq_src = 8'h00;
    bus_read(A_PEND, d);
    if (d !== 32'h10) begin errors++; $display("FAIL w1c_race: got %h want 00000010", d); end
    checks++;
    bus_write(A_PEND, 32'h10);
    bus_read(A_PEND, d);
    if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h want 0", d); end
    checks++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(A_MASK, 32'h05);
    pulse_src(8'h01);
    tick();
    pulse_src(8'h04);
    if (bus_if.irq_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", bus_if.irq_o); end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if (bus_if.irq_o !== 1'b0 || bus_if.irq_addr_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_async: got irq=%b addr=%h want irq=0 addr=0", bus_if.irq_o, bus_if.irq_addr_o);
    end
    checks++;
    tick();
    rst = 1'b0;
    bus_read(A_PEND, d);
    if (d !== 32'h0) begin errors++; $display("FAIL rstmid_pend: got %h want 0", d); end
    checks++;
    bus_read(A_MASK, d);
    if (d !== 32'h0) begin errors++; $display("FAIL rstmid_mask: got %h want 0", d); end
    checks++;
    repeat (4) tick();
    if (bus_if.irq_o !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got %b want 0", bus_if.irq_o); end
    checks++;
  endtask

  task automatic test_random;
    logic [7:0]  m_pend, m_mask, m_prev, src, w1c, clr, req;
    logic [3:0]  m_id;
    int          m_phase;
    logic        m_irq, iack, we, re, hit;
    logic [31:0] m_addr, m_dout, addr, din;
    logic [1:0]  off;
    int          op;
    bit          found;

    rst = 1'b1;
    irq_src = 8'h00;
    tick();
    rst = 1'b0;
    m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0; m_phase = 0;
    m_irq = 0; m_addr = 0; m_dout = 0;

    for (int c = 0; c < 400; c++) begin
      src  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      iack = ($urandom_range(0, 3) == 0);
      op   = $urandom_range(0, 7);
      din  = $urandom;
      addr = RB + 32'(4 * $urandom_range(0, 3));
      we = 1'b0; re = 1'b0;
      case (op)
        0: begin addr = A_MASK; we = 1'b1; end
        1: begin addr = A_EOI;  we = 1'b1; end
        2: begin addr = A_PEND; we = 1'b1; end
        3, 4, 5: re = 1'b1;
        6: begin
          addr = 32'h1234_5600 | 32'(4 * $urandom_range(0, 3));
          we = $urandom_range(0, 1) == 1;
          re = !we;
        end
        default: ;
      endcase

      irq_src           = src;
      bus_if.iack_i     = iack;
      bus_if.reg_addr_i = addr;
      bus_if.reg_din_i  = din;
      bus_if.reg_we_i   = we;
      bus_if.reg_re_i   = re;

      hit = (addr[31:4] == RB[31:4]);
      off = addr[3:2];
      if (re) begin
        if (!hit)           m_dout = 0;
        else if (off == 0)  m_dout = {24'd0, m_pend};
        else if (off == 1)  m_dout = {24'd0, m_mask};
        else if (off == 2)  m_dout = (m_phase != 0) ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
        else                m_dout = 0;
      end
      w1c = (we && hit && off == 0) ? din[7:0] : 8'h00;
      req = m_pend & m_mask;
      clr = 8'h00;
      if (m_phase == 0 && req != 0) begin
        found = 0;
        for (int i = 0; i < 8; i++) begin
          if (!found && req[i]) begin
            found = 1;
            m_id  = 4'(i);
          end
        end
        clr     = 8'(1 << m_id);
        m_phase = 1;
        m_irq   = 1;
        m_addr  = 32'h80 + 32'(m_id) * 16;
      end else if (m_phase == 1 && iack) begin
        m_phase = 2;
        m_irq   = 0;
      end else if (m_phase == 2 && we && hit && off == 3) begin
        m_phase = 0;
        m_id    = 0;
      end
      m_pend = (m_pend & ~w1c & ~clr) | (src & ~m_prev);
      if (we && hit && off == 1) m_mask = din[7:0];
      m_prev = src;

      tick();
      if (bus_if.irq_o !== m_irq) begin errors++; $display("FAIL rand_irq c=%0d: got %b want %b", c, bus_if.irq_o, m_irq); end
      checks++;
      if (bus_if.irq_addr_o !== m_addr) begin errors++; $display("FAIL rand_addr c=%0d: got %h want %h", c, bus_if.irq_addr_o, m_addr); end
      checks++;
      if (bus_if.reg_dout_o !== m_dout) begin errors++; $display("FAIL rand_dout c=%0d: got %h want %h", c, bus_if.reg_dout_o, m_dout); end
      checks++;
    end
    irq_src = 8'h00;
    bus_if.iack_i   = 1'b0;
    bus_if.reg_we_i = 1'b0;
    bus_if.reg_re_i = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    irq_src           = 8'h00;
    bus_if.iack_i     = 1'b0;
    bus_if.reg_addr_i = 32'h0;
    bus_if.reg_din_i  = 32'h0;
    bus_if.reg_we_i   = 1'b0;
    bus_if.reg_re_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_priority();
    test_masked();
    test_serv_reentry();
    test_w1c_race();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
